// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encoding
// and the alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Halves need an even address, words (and the reserved size) a 4-byte one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane handling: extracts and extends load data from a
// memory word, and merges sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [3:0]  mask_s;
  logic [31:0] repl_s;

  // Select the addressed lanes and sign/zero-extend them to 32 bits.
  always_comb begin
    shifted_s = rword_i >> {addr_lo_i, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SIZE_BYTE: load_data_o = unsigned_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: load_data_o = unsigned_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default:   load_data_o = rword_i;
    endcase
  end

  // Overwrite only the addressed lanes of the read word with store data.
  always_comb begin
    case (size_i)
      SIZE_BYTE: begin
        mask_s = 4'b0001 << addr_lo_i;
        repl_s = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        mask_s = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        repl_s = {2{wdata_i[15:0]}};
      end
      default: begin
        mask_s = 4'b1111;
        repl_s = wdata_i;
      end
    endcase
    merged_o = rword_i;
    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = mask_s[i] ? repl_s[8*i +: 8] : rword_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Loads and word stores make one memory
// access; byte/half stores do a read-modify-write; misaligned requests are
// answered with an error and never touch memory.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_data,
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  output logic [31:0] mem_out_addr,
  output logic        mem_out_valid,
  input  logic        mem_out_ready,
  input  logic [31:0] mem_out_data
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  lsu_lane_align u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .addr_lo_i   (addr_q[1:0]),
    .rword_i     (mem_out_data),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Misaligned requests idle one cycle (pend_q) so every single-step outcome
  // shares the same two-cycle response latency; ready stays low meanwhile.
  assign req_ready     = (state_q == IDLE) && !pend_q && !reset;
  assign mem_out_valid = (state_q == READ);
  assign mem_in_valid  = (state_q == WRITE);
  assign resp_valid    = (state_q == RESP);
  assign resp_error    = (state_q == RESP) && err_q;
  assign resp_rdata    = rdata_q;
  assign mem_out_addr  = {addr_q[31:2], 2'b00};
  assign mem_in_addr   = {addr_q[31:2], 2'b00};
  assign mem_in_data   = mem_wdata_q;

  // Next-state and datapath-capture decisions for the request FSM.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    pend_d      = pend_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = RESP;
        end else if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0000_0000;
          err_d   = is_misaligned(req_size, req_addr[1:0]);
          if (is_misaligned(req_size, req_addr[1:0])) begin
            pend_d = 1'b1;
          end else if (req_write && (req_size != SIZE_BYTE) && (req_size != SIZE_HALF)) begin
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (mem_out_ready) begin
          if (write_q) begin
            mem_wdata_d = merged_s;
            state_d     = WRITE;
          end else begin
            rdata_d = load_data_s;
            state_d = RESP;
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (mem_in_ready) begin
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
